delay_timer_arbiter: RTL and testbench
======================================

// Module: delay_timer_arbiter
// PURPOSE
//  Shares one millisecond delay timer among NREQ requesters, e.g. the LCD init
//  sequencer, LCD write engine and clock-tick logic.
//  Each requester pulses req[i] with its delay_ms value. The block queues it and
//  grants the timer round-robin. It returns a one-cycle done[i] pulse after
//  exactly delay_ms milliseconds of timer run time.
//  It replaces one private delay timer per LCD client.
// PARAMETERS
//  NREQ       4  number of requesters, >=2
//  MFREQ_KHZ  1  mclk cycles per millisecond, >=1 (20000 for a 20 MHz mclk)
// PORTS
//  mclk      in   1        clock; all logic is on posedge
//  rst       in   1        synchronous, active-high reset
//  req       in   NREQ     req[i]=1 for one cycle requests one delay for client i
//  delay_ms  in   16*NREQ  client i delay in ms = delay_ms[16*i+15:16*i]; sampled with req[i]
//  done      out  NREQ     one-cycle pulse: delay of client i has expired
//  busy      out  1        timer is allocated (state != IDLE)
//  grant_id  out  CLOG2    index of the client being timed; CLOG2=max(1,$clog2(NREQ))
// BEHAVIOUR
//  Queue
//   - pending[i] and dly[i] (16 b) are held per client.
//   - req[i] with pending[i]=0: set pending[i]; dly[i]<=delay_ms slice.
//   - req[i] with pending[i]=1: ignored. dly[i] is unchanged; the request is dropped.
//   - Client i may re-request while it is being served: pending[i] is already clear.
//  Arbitration
//   - req is level-sampled, so a req held high for k cycles is k requests. Only pulses are legal.
//   - Candidate vector: cand = pending | req (same-cycle bypass).
//     Where cand comes from req, the delay is taken from delay_ms.
//   - Winner is the first set bit of cand, searching ptr, ptr+1, ..., wrapping mod NREQ.
//   - On grant of w: pending[w] is cleared; the winner's delay is loaded into rem.
//   - ptr resets to 0. On DONE it becomes grant_id+1 mod NREQ.
//  FSM: IDLE, RUN, DONE
//   - IDLE: if cand!=0 at the edge, grant as above. Then grant_id<=w, presc<=0.
//     Next state is RUN if the delay !=0, else DONE.
//   - RUN: presc counts 0..MFREQ_KHZ-1 and wraps; each wrap is one ms tick.
//     On a tick with rem==1 -> DONE; otherwise rem<=rem-1.
//   - DONE: done[grant_id]=1 for this single cycle; ptr updates; next state IDLE.
//     There is no arbitration in DONE, so back-to-back grants have a 1-cycle IDLE gap.
//  Timing
//   - Request granted from IDLE in cycle 0: RUN occupies cycles 1..D*MFREQ_KHZ.
//     done is asserted in cycle D*MFREQ_KHZ+1.
//   - Delay 0: done in cycle 1.
//   - Maximum delay 65535 ms. rem is 16 b; presc is $clog2(MFREQ_KHZ)+1 b.
//  Outputs
//   - done is decoded from state==DONE and grant_id; it is never multi-hot.
//   - busy=1 in RUN and DONE.
//   - grant_id holds its last value in IDLE.
//  Reset
//   - Reset values: done=0, busy=0, grant_id=0; pending, dly, rem, presc, ptr all 0; state=IDLE.
//   - rst wins over req in the same cycle.
//   - rst mid-RUN aborts the delay silently: no done pulse, and all queued requests are lost.
// TESTING (NREQ=4, MFREQ_KHZ=3, cycle 0 = first cycle after rst release)
//  1. Hold rst 3 cycles with req=4'hF -> done=0, busy=0, grant_id=0. No done for 20 cycles after release.
//  2. req=4'b0010, delay=2 in cycle 0 -> busy cycles 1..7, grant_id=1, done=4'b0010 only in cycle 7.
//  3. req[2] with delay=0 in cycle 0 -> done[2] in cycle 1, busy only in cycle 1.
//  4. req=4'b1011, all delays=1, in cycle 0 -> done[0]@4, done[1]@9, done[3]@14; one done per pulse.
//  5. Fairness:
//     - Start from test 4 and pulse req[0] (delay=1) in cycle 2.
//     - Required: done[1]@9, done[3]@14, done[0]@19. Client 0 must not preempt 1 or 3.
//     - Extra req[1] pulses in cycles 3 and 4 are dropped: one done[1] only.
//  6. req[3], delay=100, in cycle 0; rst in cycle 50 -> busy=0 in cycle 51; no done[3]. A new req[3] then completes normally.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one millisecond delay timer among NREQ clients.
// Each client queues one delay and receives a single done pulse when it expires.
module delay_timer_arbiter #(
  parameter int NREQ      = 4,
  parameter int MFREQ_KHZ = 1,
  localparam int CW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int PW = $clog2(MFREQ_KHZ) + 1
) (
  input  logic               mclk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] delay_ms,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      grant_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PW-1:0] PMAX = PW'(MFREQ_KHZ - 1);
  localparam logic [CW-1:0] LAST = CW'(NREQ - 1);

  state_t          state;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] cand;
  logic [15:0]     dly [NREQ];
  logic [15:0]     rem;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   ptr;
  logic            found;
  logic [CW-1:0]   win;
  logic [15:0]     win_dly;
  int              idx;

  // Same-cycle requests join the search so an idle timer starts at once.
  always_comb begin
    cand  = pending | req;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
    win_dly = pending[win] ? dly[win] : delay_ms[16*win +: 16];
  end

  always_comb begin
    done = '0;
    if (state == DONE) done[grant_id] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge mclk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      rem      <= '0;
      presc    <= '0;
      ptr      <= '0;
      grant_id <= '0;
      for (int i = 0; i < NREQ; i++) dly[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          dly[i]     <= delay_ms[16*i +: 16];
        end
      end
      unique case (state)
        IDLE: begin
          if (found) begin
            pending[win] <= 1'b0;
            rem          <= win_dly;
            grant_id     <= win;
            presc        <= '0;
            state        <= (win_dly != 16'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (presc == PMAX) begin
            presc <= '0;
            if (rem == 16'd1) state <= DONE;
            else rem <= rem - 16'd1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        DONE: begin
          ptr   <= (grant_id == LAST) ? '0 : grant_id + CW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with NREQ=4, MFREQ_KHZ=3.
// Scenario table drives pulses and lists the cycles each done must fire.
module tb_delay_timer_arbiter;

  localparam int NREQ = 4;
  localparam int MF   = 3;
  localparam int NCYC = 24;

  logic        mclk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] delay_ms;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  grant_id;

  int nvec  = 0;
  int nfail = 0;

  delay_timer_arbiter #(.NREQ(NREQ), .MFREQ_KHZ(MF)) dut (
    .mclk(mclk), .rst(rst), .req(req), .delay_ms(delay_ms),
    .done(done), .busy(busy), .grant_id(grant_id)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [3:0][7:0]  pcyc;
    logic [3:0][3:0]  preq;
    logic [3:0][15:0] pdly;
    logic [3:0][7:0]  dc;
    logic [3:0][7:0]  dc2;
    logic [31:0]      bmask;
    string            name;
  } sc_t;

  sc_t sc [6];

  task automatic cyc_check(input string nm, input int c,
                           input logic [3:0] ed, input logic eb,
                           input logic [1:0] eg);
    @(negedge mclk);
    nvec++;
    if (done !== ed || busy !== eb || grant_id !== eg) begin
      nfail++;
      $display("FAIL %s cyc=%0d got done=%b busy=%b gid=%0d want done=%b busy=%b gid=%0d",
               nm, c, done, busy, grant_id, ed, eb, eg);
    end
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    delay_ms = '0;
    repeat (3) @(posedge mclk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    sc[0] = '{ {8'hFF,8'hFF,8'hFF,8'd0}, {4'h0,4'h0,4'h0,4'b0010},
               {16'd0,16'd0,16'd0,16'd2}, {8'hFF,8'hFF,8'd7,8'hFF},
               {8'hFF,8'hFF,8'hFF,8'hFF}, 32'h0000_00FE, "single" };
    sc[1] = '{ {8'hFF,8'hFF,8'hFF,8'd0}, {4'h0,4'h0,4'h0,4'b0100},
               {16'd0,16'd0,16'd0,16'd0}, {8'hFF,8'd1,8'hFF,8'hFF},
               {8'hFF,8'hFF,8'hFF,8'hFF}, 32'h0000_0002, "zero" };
    sc[2] = '{ {8'hFF,8'hFF,8'hFF,8'd0}, {4'h0,4'h0,4'h0,4'b1011},
               {16'd0,16'd0,16'd0,16'd1}, {8'd14,8'hFF,8'd9,8'd4},
               {8'hFF,8'hFF,8'hFF,8'hFF}, 32'h0000_7BDE, "three" };
    sc[3] = '{ {8'd4,8'd3,8'd2,8'd0}, {4'b0010,4'b0010,4'b0001,4'b1011},
               {16'd1,16'd1,16'd1,16'd1}, {8'd14,8'hFF,8'd9,8'd4},
               {8'hFF,8'hFF,8'hFF,8'd19}, 32'h000F_7BDE, "fair" };
    sc[4] = '{ {8'hFF,8'hFF,8'hFF,8'd0}, {4'h0,4'h0,4'h0,4'b0101},
               {16'd0,16'd0,16'd0,16'd0}, {8'hFF,8'd3,8'hFF,8'd1},
               {8'hFF,8'hFF,8'hFF,8'hFF}, 32'h0000_000A, "twozero" };
    sc[5] = '{ {8'hFF,8'hFF,8'hFF,8'd0}, {4'h0,4'h0,4'h0,4'b1000},
               {16'd0,16'd0,16'd0,16'd3}, {8'd10,8'hFF,8'hFF,8'hFF},
               {8'hFF,8'hFF,8'hFF,8'hFF}, 32'h0000_07FE, "long" };

    // reset with all requests held high
    rst = 1'b1;
    req = 4'hF;
    delay_ms = {4{16'd5}};
    @(posedge mclk);
    #1;
    for (int c = 0; c < 2; c++) cyc_check("rst_hold", c, 4'b0, 1'b0, 2'd0);
    rst = 1'b0;
    req = '0;
    delay_ms = '0;
    for (int c = 0; c < 20; c++) cyc_check("post_rst", c, 4'b0, 1'b0, 2'd0);

    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < NCYC; c++) begin
        logic [3:0] ed;
        logic [1:0] eg;
        int best;
        req = '0;
        delay_ms = '0;
        for (int p = 0; p < 4; p++) begin
          if (int'(sc[s].pcyc[p]) == c) begin
            req = req | sc[s].preq[p];
            for (int i = 0; i < 4; i++)
              if (sc[s].preq[p][i]) delay_ms[16*i +: 16] = sc[s].pdly[p];
          end
        end
        ed = '0;
        for (int i = 0; i < 4; i++)
          ed[i] = (int'(sc[s].dc[i]) == c) || (int'(sc[s].dc2[i]) == c);
        // busy: client whose done is next; idle: client whose done was last
        eg = 2'd0;
        best = sc[s].bmask[c] ? 1000 : -1;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 2; j++) begin
            int d;
            d = (j == 0) ? int'(sc[s].dc[i]) : int'(sc[s].dc2[i]);
            if (d != 255) begin
              if (sc[s].bmask[c] && d >= c && d < best) begin
                best = d;
                eg = 2'(i);
              end
              if (!sc[s].bmask[c] && d < c && d > best) begin
                best = d;
                eg = 2'(i);
              end
            end
          end
        end
        cyc_check(sc[s].name, c, ed, sc[s].bmask[c], eg);
      end
    end

    // long delay aborted by reset; queued req[1] must be lost too
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      logic eb;
      logic [1:0] eg;
      req = '0;
      delay_ms = '0;
      rst = (c == 50);
      if (c == 0) begin
        req = 4'b1000;
        delay_ms[63:48] = 16'd100;
      end
      if (c == 10) begin
        req = 4'b0010;
        delay_ms[31:16] = 16'd1;
      end
      if (c == 52) begin
        req = 4'b1000;
        delay_ms[63:48] = 16'd1;
      end
      eb = (c >= 1 && c <= 50) || (c >= 53 && c <= 56);
      eg = ((c >= 1 && c <= 50) || c >= 53) ? 2'd3 : 2'd0;
      cyc_check("abort", c, (c == 56) ? 4'b1000 : 4'b0000, eb, eg);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
